axis_video_tpg: RTL and testbench
=================================

# axis_video_tpg

- AXI4-Stream video test-pattern generator: the transmitting end of the `AXIS_if` stream.
- Produces raster frames of `H_ACTIVE`×`V_ACTIVE` pixels on the `AXIS_if` master signals.
- Marks start-of-frame with `tuser` and end-of-line with `tlast`.
- Runs without backpressure and inserts programmable blanking between lines and between frames.
- Sits at the head of the video pipeline as a stimulus source for downstream AXIS slaves during bring-up and in simulation.

## Interface
Parameters:
- `BITWIDTH`, 24 — pixel width (3×8 RGB); must be ≥ 8 and a multiple of 8 is not required.
- `H_ACTIVE`, 640 — pixels per line, ≥ 2.
- `V_ACTIVE`, 480 — lines per frame, ≥ 1.
- `H_BLANK`, 16 — idle cycles after each line's `tlast`, ≥ 0.
- `V_BLANK`, 64 — additional idle cycles after the last line of a frame (after its `H_BLANK`), ≥ 0.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `aclk` in 1 — clock.
- `aresetn` in 1 — asynchronous active-low reset.
- `enable` in 1 — run request, sampled only at frame boundaries.
- `pattern_sel` in 2 — pattern select, latched at frame start.
- `tdata` out `BITWIDTH` — pixel.
- `tlast` out 1 — last pixel of line.
- `tuser` out 1 — first pixel of frame.
- `tvalid` out 1 — beat valid; no `tready` exists, so every valid cycle is a transfer.
- `frame_done` out 1 — single-cycle pulse coincident with the last beat of a frame.

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE → ACTIVE when `enable`=1 is sampled.
- ACTIVE → HBLANK after a line's `tlast`, or directly to the next line if `H_BLANK`=0.
- After the last line's `H_BLANK`, go to VBLANK.
- VBLANK → ACTIVE when the count expires and `enable`=1; otherwise VBLANK → IDLE.
- Counters: `x` is 0..`H_ACTIVE`-1, `y` is 0..`V_ACTIVE`-1, blank counter is sized for max(`H_BLANK`,`V_BLANK`).
- Widths are `$clog2(N)` with a minimum of 1.
- `frame_cnt` is 8 bits, increments at each `frame_done`, and wraps 255→0.
- `tuser`=1 only on the beat with x=0, y=0.
- `tlast`=1 only on beats with x=`H_ACTIVE`-1.
- Patterns, with `pattern_sel` latched at frame start:
  - 0: `tdata` = x zero-extended/truncated to `BITWIDTH`.
  - 1: checker, `tdata` = all-ones when `x[3]^y[3]`, else 0.
  - 2: `tdata` = `frame_cnt` replicated into every byte; a partial top byte is truncated.
  - 3: 8 vertical colour bars. Bar index = (x·8)/`H_ACTIVE`, computed without a divider via a bar counter stepping every ⌈`H_ACTIVE`/8⌉ pixels. Bar colours: white, yellow, cyan, green, magenta, red, blue, black, as {R,G,B} bytes in `tdata[23:0]`, upper bits 0.
- Deasserting `enable` mid-frame does not truncate the frame: the frame, its `H_BLANK` and its `V_BLANK` all complete, then IDLE.
- `pattern_sel` changes mid-frame take effect at the next frame.

## Timing
- All outputs are registered.
- Reset values: `tdata`=0, `tlast`=0, `tuser`=0, `tvalid`=0, `frame_done`=0. The FSM resets to IDLE and all counters, including `frame_cnt`, reset to 0.
- Start latency: the first beat (`tuser`=1) has `tvalid`=1 in the cycle after the edge that samples `enable`=1 in IDLE.
- Each line is `H_ACTIVE` consecutive valid cycles, followed by exactly `H_BLANK` cycles of `tvalid`=0.
- Frame period = `V_ACTIVE`·(`H_ACTIVE`+`H_BLANK`)+`V_BLANK` cycles.
- With `enable` held high, the next frame's `tuser` beat directly follows the last idle cycle.
- When `tvalid`=0, `tdata`, `tlast` and `tuser` are 0.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). After release, the next frame starts at x=0, y=0 with `tuser`, and there is no partial-line continuation.

## Structure
- Package `axis_tpg_pkg` holds:
  - `tpg_state_t` enum {IDLE, ACTIVE, HBLANK, VBLANK}.
  - `tpg_pattern_t` enum {PAT_RAMP, PAT_CHECKER, PAT_FRAMECNT, PAT_BARS}.
  - The 8-entry colour-bar RGB constant array.
- One sub-module, `axis_tpg_pattern`: combinational pixel generation from (x, y, bar index, `frame_cnt`, pattern).
- The top-level holds the FSM, counters and output registers.
- The top-level drives an `AXIS_if.master` modport.

## Test plan
Bench parameters: `H_ACTIVE`=4, `V_ACTIVE`=3, `H_BLANK`=2, `V_BLANK`=5, `BITWIDTH`=24.
1. Reset with `enable`=0 for 20 cycles → all outputs 0 throughout, `tvalid` never asserts.
2. `enable`=1, `pattern_sel`=0 → first valid beat the cycle after sampling.
   - Beats are 0,1,2,3 per line; `tuser` only on the first beat; `tlast` on each 4th beat.
   - Exactly 2 idle cycles between lines.
   - `frame_done` on beat 12; 7 idle cycles; next `tuser` at period 23.
3. `pattern_sel`=2 held over 3 frames → `tdata` = 0x000000, 0x010101, 0x020202.
4. Drop `enable` on the 5th beat → the frame completes all 12 beats plus `V_BLANK`, then IDLE, with no further `tvalid`.
5. Assert `aresetn`=0 mid-line 1 → outputs 0 the same cycle. After release with `enable`=1, the stream restarts with the `tuser` beat at x=0, y=0.
6. `pattern_sel`=3 with `H_ACTIVE`=16, plus a mid-frame `pattern_sel` change → pixel pairs map to bars white…black (0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000). The change applies only from the next frame.

Source files
------------

// File: rtl/axis_tpg_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern generator.
// Holds FSM/pattern enums, the colour-bar table and a width helper.
package axis_tpg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } tpg_state_t;

  typedef enum logic [1:0] {
    PAT_RAMP     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_FRAMECNT = 2'd2,
    PAT_BARS     = 2'd3
  } tpg_pattern_t;

  // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream video bundle without tready; the master owns every signal.
// Any cycle with tvalid=1 is a completed transfer (the sink cannot stall).
interface AXIS_if #(
  parameter int BITWIDTH = 24
);

  logic [BITWIDTH-1:0] tdata;
  logic                tlast;
  logic                tuser;
  logic                tvalid;

  modport master (output tdata, output tlast, output tuser, output tvalid);
  modport slave  (input  tdata, input  tlast, input  tuser, input  tvalid);

endinterface

// File: rtl/axis_tpg_pattern.sv
// Combinational pixel generator: maps raster position, bar index and frame
// count to a pixel for the selected test pattern.
module axis_tpg_pattern
  import axis_tpg_pkg::*;
#(
  parameter int BITWIDTH = 24,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic [XW-1:0]       x,
  input  logic [YW-1:0]       y,
  input  logic [2:0]          bar,
  input  logic [7:0]          frame_cnt,
  input  tpg_pattern_t        pattern,
  output logic [BITWIDTH-1:0] pixel
);

  localparam int NBYTES = (BITWIDTH + 7) / 8;

  logic                x_b3;
  logic                y_b3;
  logic [8*NBYTES-1:0] cnt_rep;

  // Bit 3 of each coordinate; reads as 0 when the counter is narrower.
  assign x_b3    = |(x & XW'(8));
  assign y_b3    = |(y & YW'(8));
  assign cnt_rep = {NBYTES{frame_cnt}};

  always_comb begin
    pixel = '0;
    case (pattern)
      PAT_RAMP:     pixel = BITWIDTH'(x);
      PAT_CHECKER:  pixel = (x_b3 ^ y_b3) ? '1 : '0;
      PAT_FRAMECNT: pixel = BITWIDTH'(cnt_rep);
      PAT_BARS:     pixel = BITWIDTH'(BAR_RGB[bar]);
      default:      pixel = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_tpg.sv
// AXI4-Stream raster test-pattern source with programmable line/frame
// blanking; FSM, raster counters and registered stream outputs live here.
module axis_video_tpg
  import axis_tpg_pkg::*;
#(
  parameter int BITWIDTH = 24,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 64
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable,
  input  logic [1:0]          pattern_sel,
  output logic [BITWIDTH-1:0] tdata,
  output logic                tlast,
  output logic                tuser,
  output logic                tvalid,
  output logic                frame_done,
  output tpg_state_t          fsm_state
);

  localparam int XW        = clog2_min1(H_ACTIVE);
  localparam int YW        = clog2_min1(V_ACTIVE);
  localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW        = clog2_min1(BLANK_MAX);
  localparam int BAR_STEP  = (H_ACTIVE + 7) / 8;
  localparam int SW        = clog2_min1(BAR_STEP);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] H_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BW-1:0] V_LAST = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam logic [SW-1:0] S_LAST = SW'(BAR_STEP - 1);

  tpg_state_t   state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [2:0]    bar, bar_n;
  logic [SW-1:0] sub, sub_n;
  logic [BW-1:0] blank, blank_n;
  tpg_pattern_t  pat_q, pat_n;
  logic [7:0]    frame_cnt;

  logic                line_done;
  logic                frame_end;
  logic                start_frame;
  logic                next_line;
  logic                beat_n;
  logic                last_beat_n;
  logic [BITWIDTH-1:0] pixel;

  logic [BITWIDTH-1:0] tdata_q;
  logic                tlast_q;
  logic                tuser_q;
  logic                tvalid_q;
  logic                done_q;

  AXIS_if #(.BITWIDTH(BITWIDTH)) m_axis ();

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      bar       <= '0;
      sub       <= '0;
      blank     <= '0;
      pat_q     <= PAT_RAMP;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      bar   <= bar_n;
      sub   <= sub_n;
      blank <= blank_n;
      pat_q <= pat_n;
      if (last_beat_n) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // state names what the output registers show in the same cycle.
  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    bar_n       = bar;
    sub_n       = sub;
    blank_n     = blank;
    pat_n       = pat_q;
    line_done   = 1'b0;
    frame_end   = 1'b0;
    start_frame = 1'b0;
    next_line   = 1'b0;

    case (state)
      IDLE: start_frame = enable;
      ACTIVE: begin
        if (x == X_LAST) begin
          if (H_BLANK > 0) begin
            state_n = HBLANK;
            blank_n = '0;
          end else begin
            line_done = 1'b1;
          end
        end else begin
          x_n = x + XW'(1);
          if (sub == S_LAST) begin
            sub_n = '0;
            bar_n = bar + 3'd1;
          end else begin
            sub_n = sub + SW'(1);
          end
        end
      end
      HBLANK: begin
        if (blank == H_LAST) line_done = 1'b1;
        else                 blank_n   = blank + BW'(1);
      end
      VBLANK: begin
        if (blank == V_LAST) frame_end = 1'b1;
        else                 blank_n   = blank + BW'(1);
      end
      default: state_n = IDLE;
    endcase

    if (line_done) begin
      if (y != Y_LAST) begin
        next_line = 1'b1;
      end else if (V_BLANK > 0) begin
        state_n = VBLANK;
        blank_n = '0;
      end else begin
        frame_end = 1'b1;
      end
    end

    // enable only matters here and in IDLE, so a frame always completes.
    if (frame_end) begin
      if (enable) start_frame = 1'b1;
      else        state_n     = IDLE;
    end

    if (start_frame) begin
      state_n = ACTIVE;
      x_n     = '0;
      y_n     = '0;
      bar_n   = '0;
      sub_n   = '0;
      pat_n   = tpg_pattern_t'(pattern_sel);
    end

    if (next_line) begin
      state_n = ACTIVE;
      x_n     = '0;
      y_n     = y + YW'(1);
      bar_n   = '0;
      sub_n   = '0;
    end
  end

  assign beat_n      = (state_n == ACTIVE);
  assign last_beat_n = beat_n && (x_n == X_LAST) && (y_n == Y_LAST);

  axis_tpg_pattern #(
    .BITWIDTH (BITWIDTH),
    .XW       (XW),
    .YW       (YW)
  ) u_pattern (
    .x         (x_n),
    .y         (y_n),
    .bar       (bar_n),
    .frame_cnt (frame_cnt),
    .pattern   (pat_n),
    .pixel     (pixel)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tdata_q  <= beat_n ? pixel : '0;
      tlast_q  <= beat_n && (x_n == X_LAST);
      tuser_q  <= beat_n && (x_n == '0) && (y_n == '0);
      tvalid_q <= beat_n;
      done_q   <= last_beat_n;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tvalid = tvalid_q;

  assign tdata      = m_axis.tdata;
  assign tlast      = m_axis.tlast;
  assign tuser      = m_axis.tuser;
  assign tvalid     = m_axis.tvalid;
  assign frame_done = done_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_axis_video_tpg.sv
// Bench for axis_video_tpg: a 4x3 instance for timing/ramp/frame-count/reset
// scenarios and a 16x2 instance for colour bars and pattern switching.
`timescale 1ns/1ps
module tb_axis_video_tpg;
  import axis_tpg_pkg::*;

  localparam int EW  = 59;  // {cycle[31:0], tdata[23:0], tlast, tuser, frame_done}
  localparam int P1  = 23;  // 3*(4+2)+5
  localparam int P2  = 41;  // 2*(16+2)+5
  localparam int L2  = 18;  // 16+2

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en1, en2;
  logic [1:0] pat1, pat2;

  logic [23:0] tdata1, tdata2;
  logic tlast1, tuser1, tvalid1, done1;
  logic tlast2, tuser2, tvalid2, done2;
  tpg_state_t st1, st2;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp1_q[$];
  logic [EW-1:0] exp2_q[$];
  logic [EW-1:0] e1, e2;

  typedef struct {
    int   off;
    int   x;
    int   y;
    logic tlast;
    logic tuser;
    logic done;
  } beat_t;
  beat_t ramp_tab[12];

  typedef struct {
    int          x;
    logic [23:0] rgb;
  } bar_vec_t;
  bar_vec_t    bar_tab[16];
  logic [23:0] colours[8];

  axis_video_tpg #(
    .BITWIDTH(24), .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_BLANK(5)
  ) dut1 (
    .aclk(clk), .aresetn(rst_n), .enable(en1), .pattern_sel(pat1),
    .tdata(tdata1), .tlast(tlast1), .tuser(tuser1), .tvalid(tvalid1),
    .frame_done(done1), .fsm_state(st1)
  );

  axis_video_tpg #(
    .BITWIDTH(24), .H_ACTIVE(16), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(5)
  ) dut2 (
    .aclk(clk), .aresetn(rst_n), .enable(en2), .pattern_sel(pat2),
    .tdata(tdata2), .tlast(tlast2), .tuser(tuser2), .tvalid(tvalid2),
    .frame_done(done2), .fsm_state(st2)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitors, sampling on the falling edge
  always @(negedge clk) begin
    if (tvalid1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1 unexpected beat: got tdata=%h at cycle %0d, expected no beat", tdata1, cyc);
      end else begin
        e1 = exp1_q.pop_front();
        check("dut1 beat {cycle,tdata,tlast,tuser,done}",
              64'({32'(cyc), tdata1, tlast1, tuser1, done1}), 64'(e1));
      end
    end else begin
      check("dut1 idle outputs", 64'({tvalid1, tdata1, tlast1, tuser1, done1}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (tvalid2 === 1'b1) begin
      if (exp2_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2 unexpected beat: got tdata=%h at cycle %0d, expected no beat", tdata2, cyc);
      end else begin
        e2 = exp2_q.pop_front();
        check("dut2 beat {cycle,tdata,tlast,tuser,done}",
              64'({32'(cyc), tdata2, tlast2, tuser2, done2}), 64'(e2));
      end
    end else begin
      check("dut2 idle outputs", 64'({tvalid2, tdata2, tlast2, tuser2, done2}), 64'd0);
    end
  end

  // driver tasks
  task automatic push_frame1(input int start, input int pat, input int fcnt);
    logic [7:0]  f8;
    logic [23:0] d;
    f8 = fcnt[7:0];
    for (int i = 0; i < 12; i++) begin
      d = (pat == 2) ? {f8, f8, f8} : 24'(ramp_tab[i].x);
      exp1_q.push_back({32'(start + ramp_tab[i].off), d,
                        ramp_tab[i].tlast, ramp_tab[i].tuser, ramp_tab[i].done});
    end
  endtask

  task automatic push_frame2(input int start, input int pat);
    logic [23:0] d;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 16; x++) begin
        case (pat)
          0:       d = 24'(x);
          1:       d = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
          default: d = bar_tab[x].rgb;
        endcase
        exp2_q.push_back({32'(start + y * L2 + x), d,
                          1'(x == 15), 1'(x == 0 && y == 0), 1'(x == 15 && y == 1)});
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain1(input int budget);
    for (int i = 0; i < budget && exp1_q.size() > 0; i++) @(negedge clk);
    check("dut1 all expected beats seen", 64'(exp1_q.size()), 64'd0);
    exp1_q.delete();
  endtask

  task automatic drain2(input int budget);
    for (int i = 0; i < budget && exp2_q.size() > 0; i++) @(negedge clk);
    check("dut2 all expected beats seen", 64'(exp2_q.size()), 64'd0);
    exp2_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int s;

    ramp_tab[0]  = '{0,  0, 0, 1'b0, 1'b1, 1'b0};
    ramp_tab[1]  = '{1,  1, 0, 1'b0, 1'b0, 1'b0};
    ramp_tab[2]  = '{2,  2, 0, 1'b0, 1'b0, 1'b0};
    ramp_tab[3]  = '{3,  3, 0, 1'b1, 1'b0, 1'b0};
    ramp_tab[4]  = '{6,  0, 1, 1'b0, 1'b0, 1'b0};
    ramp_tab[5]  = '{7,  1, 1, 1'b0, 1'b0, 1'b0};
    ramp_tab[6]  = '{8,  2, 1, 1'b0, 1'b0, 1'b0};
    ramp_tab[7]  = '{9,  3, 1, 1'b1, 1'b0, 1'b0};
    ramp_tab[8]  = '{12, 0, 2, 1'b0, 1'b0, 1'b0};
    ramp_tab[9]  = '{13, 1, 2, 1'b0, 1'b0, 1'b0};
    ramp_tab[10] = '{14, 2, 2, 1'b0, 1'b0, 1'b0};
    ramp_tab[11] = '{15, 3, 2, 1'b1, 1'b0, 1'b1};

    colours = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    for (int i = 0; i < 16; i++) bar_tab[i] = '{i, colours[i / 2]};

    en1 = 1'b0; en2 = 1'b0; pat1 = 2'd0; pat2 = 2'd0;

    // 1: reset held with enable low, then stay idle
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    check("dut1 state in reset", 64'(st1), 64'(IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("dut1 state idle after reset", 64'(st1), 64'(IDLE));

    // 2: ramp, start latency, blanking and frame period
    c = cyc; pat1 = 2'd0; en1 = 1'b1;
    push_frame1(c + 1, 0, 0);
    push_frame1(c + 1 + P1, 0, 1);
    wait_until(c + 1 + P1);
    en1 = 1'b0;
    drain1(60);
    repeat (10) @(negedge clk);
    check("dut1 idle after ramp frames", 64'(st1), 64'(IDLE));

    // 3: frame counter pattern over three frames from a fresh reset
    do_reset(2);
    c = cyc; pat1 = 2'd2; en1 = 1'b1;
    for (int f = 0; f < 3; f++) push_frame1(c + 1 + f * P1, 2, f);
    wait_until(c + 1 + 2 * P1);
    en1 = 1'b0;
    drain1(60);
    repeat (10) @(negedge clk);

    // 4: enable dropped on the 5th beat; frame and V_BLANK still complete
    c = cyc; pat1 = 2'd0; en1 = 1'b1;
    push_frame1(c + 1, 0, 0);
    wait_until(c + 1 + 6);
    en1 = 1'b0;
    wait_until(c + 1 + 19);
    check("dut1 vblank runs after enable drop", 64'(st1), 64'(VBLANK));
    drain1(60);
    repeat (10) @(negedge clk);
    check("dut1 idle after truncated-enable frame", 64'(st1), 64'(IDLE));

    // 5: asynchronous reset mid-line, then clean restart
    c = cyc; pat1 = 2'd0; en1 = 1'b1;
    push_frame1(c + 1, 0, 0);
    wait_until(c + 1 + 7);
    check("dut1 valid mid-line before reset", 64'(tvalid1), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("dut1 outputs clear on async reset",
          64'({tvalid1, tdata1, tlast1, tuser1, done1}), 64'd0);
    check("dut1 state idle on async reset", 64'(st1), 64'(IDLE));
    exp1_q.delete();
    repeat (3) @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    push_frame1(c + 1, 0, 0);
    wait_until(c + 2);
    en1 = 1'b0;
    drain1(60);
    repeat (10) @(negedge clk);

    // 6: colour bars, then mid-frame pattern changes taking effect next frame
    c = cyc; pat2 = 2'd3; en2 = 1'b1;
    s = c + 1;
    push_frame2(s, 3);
    push_frame2(s + P2, 0);
    push_frame2(s + 2 * P2, 1);
    wait_until(s + 5);
    pat2 = 2'd0;
    wait_until(s + P2 + 5);
    pat2 = 2'd1;
    wait_until(s + 2 * P2);
    en2 = 1'b0;
    pat2 = 2'd2;
    drain2(120);
    repeat (10) @(negedge clk);
    check("dut2 idle after bar frames", 64'(st2), 64'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
